alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  FIFO can accept a command.
REQ-006 cmd_opcode  input  4  ALU opcode, same encoding the ALU uses.
REQ-007 cmd_a, cmd_b  input  8 each  operands.
REQ-008 cmd_nbit  input  4  shift amount.
REQ-009 Opcode, A, B, N_bit  output  4/8/8/4  registered operand drive to the ALU.
REQ-010 alu_out  input  16  combinational result returned by the ALU.
REQ-011 res_valid  output  1  result held.
REQ-012 res_ready  input  1  consumer accepts the result.
REQ-013 res_data  output  16  captured result.
REQ-014 res_err  output  1  divide-by-zero flag for res_data (only when DIVZ_CHECK_EN is defined).
REQ-015 busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-016 Push: cmd_valid && cmd_ready at an edge writes {opcode,a,b,nbit} to the FIFO tail.
REQ-017 cmd_ready = (count != DEPTH); it does not depend on a same-cycle pop.
REQ-018 Pointers wrap modulo DEPTH; count range 0..DEPTH; a push and a pop at the same edge leave count unchanged.
REQ-019 FSM states: IDLE, ISSUE, HOLD.
REQ-020 IDLE: if count != 0, pop the head into Opcode/A/B/N_bit, go ISSUE; else stay.
REQ-021 ISSUE: capture alu_out into res_data, set res_valid=1, go HOLD; this state always lasts exactly one cycle.
REQ-022 HOLD: res_data, res_valid and the operand outputs are stable while res_ready=0.
REQ-023 HOLD with res_ready=1: clear res_valid. If count != 0, pop the next command in the same edge and go ISSUE; otherwise go IDLE.
REQ-024 Latency: a command pushed into an empty FIFO in an idle block at edge N is popped at N+1, and res_valid rises at N+2.
REQ-025 Sustained throughput: one result per 2 cycles while res_ready=1.
REQ-026 Operand outputs change only on a pop; at all other times they hold their last values.
REQ-027 Results are delivered in push order; no command is dropped or duplicated.
REQ-028 A push into a full FIFO is impossible by handshake; cmd_valid while full has no effect.

Reset
REQ-029 rst=1 at an edge forces state IDLE, pointers and count to 0, Opcode/A/B/N_bit=0, res_data=0, res_valid=0, res_err=0.
REQ-030 Reset mid-operation (ISSUE or HOLD) discards the in-flight result and all queued commands.
REQ-031 rst has priority over push, pop and capture.
REQ-032 cmd_ready is 1 from the first edge after reset deassertion.

Configuration
REQ-033 Macro DIVZ_CHECK_EN.
REQ-034 With DIVZ_CHECK_EN defined: a popped command with opcode 4'b0011 and B==0 captures res_data=16'hFFFF and res_err=1, ignoring alu_out. Otherwise res_err=0 at capture.
REQ-035 Without DIVZ_CHECK_EN: the res_err port is absent, and alu_out is captured unconditionally.

Verification
REQ-036 Single op: push opcode 0000, A=8'd200, B=8'd100 into an idle block with res_ready=1 -> res_valid rises 2 edges after the push with res_data=16'd300, and busy falls afterwards.
REQ-037 Fill/backpressure: hold res_ready=0 and push 5 commands with DEPTH=4 -> the first is popped. cmd_ready falls after the 5th accept, and a 6th offer is not accepted. After res_ready is released, 5 results appear in order.
REQ-038 Stall: hold res_ready=0 for 10 cycles during HOLD for opcode 0010, A=8'd15, B=8'd17 -> res_data=16'd255 is stable for all 10 cycles, and the operand outputs do not change.
REQ-039 Back-to-back: queue 4 ops with res_ready=1 -> results arrive every 2 cycles, with no gaps and in push order.
REQ-040 Reset in HOLD: with 3 commands queued, assert rst for one cycle -> all outputs return to their reset values and count is 0. A fresh push of opcode 0001, A=9, B=4 yields res_data=16'd5.
REQ-041 Divide-by-zero with DIVZ_CHECK_EN defined: opcode 0011, A=8'd50, B=0 -> res_data=16'hFFFF and res_err=1. The next op, opcode 0011, A=50, B=5, gives res_data=16'd10 and res_err=0.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: command FIFO feeding a combinational ALU through registered
// operand outputs, with a one-entry result holding register.
// Optional feature macro: DIVZ_CHECK_EN (divide-by-zero detection, res_err port).
module alu_issue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_nbit,
  output logic [3:0]  Opcode,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [3:0]  N_bit,
  input  logic [15:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
`ifdef DIVZ_CHECK_EN
  output logic        res_err,
`endif
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [23:0]   mem_q [DEPTH];
  logic [23:0]   mem_d [DEPTH];
  logic [3:0]    opcode_q, opcode_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic [3:0]    nbit_q, nbit_d;
  logic          res_valid_q, res_valid_d;
  logic [15:0]   res_data_q, res_data_d;
  logic          res_err_q, res_err_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          push_s;
  logic          pop_s;
  logic [23:0]   head_s;

  assign push_s = cmd_valid && cmd_ready_q;
  assign head_s = mem_q[rd_ptr_q];

  // Issue FSM: decides pops, result capture and operand loads.
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    case (state_q)
      IDLE: begin
        if (count_q != ZERO_C) begin
          pop_s   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        res_valid_d = 1'b1;
        state_d     = HOLD;
`ifdef DIVZ_CHECK_EN
        // Division by zero is flagged here rather than trusting the ALU value.
        if ((opcode_q == 4'b0011) && (b_q == 8'd0)) begin
          res_data_d = 16'hFFFF;
          res_err_d  = 1'b1;
        end else begin
          res_data_d = alu_out;
          res_err_d  = 1'b0;
        end
`else
        res_data_d = alu_out;
        res_err_d  = 1'b0;
`endif
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (count_q != ZERO_C) begin
            pop_s   = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand registers change only when a command is popped.
  always_comb begin
    if (pop_s) begin
      opcode_d = head_s[23:20];
      a_d      = head_s[19:12];
      b_d      = head_s[11:4];
      nbit_d   = head_s[3:0];
    end else begin
      opcode_d = opcode_q;
      a_d      = a_q;
      b_d      = b_q;
      nbit_d   = nbit_q;
    end
  end

  // FIFO bookkeeping: storage write, pointer wrap and occupancy.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {cmd_opcode, cmd_a, cmd_b, cmd_nbit};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Status outputs are registered from next-state values so they track state exactly.
    cmd_ready_d = (count_d != FULL_C);
    busy_d      = (state_d != IDLE) || (count_d != ZERO_C);
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= ZERO_C;
      opcode_q    <= 4'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      nbit_q      <= 4'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'd0;
      res_err_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      opcode_q    <= opcode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      nbit_q      <= nbit_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign cmd_ready = cmd_ready_q;
  assign Opcode    = opcode_q;
  assign A         = a_q;
  assign B         = b_q;
  assign N_bit     = nbit_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
`ifdef DIVZ_CHECK_EN
  assign res_err   = res_err_q;
`else
  logic unused_err_s;
  assign unused_err_s = res_err_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue with a small ALU stub.
module tb_alu_issue;
  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [3:0]  cmd_nbit;
  logic [3:0]  Opcode;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  N_bit;
  logic [15:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
`ifdef DIVZ_CHECK_EN
  logic        res_err;
`endif
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_issue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_nbit(cmd_nbit),
    .Opcode(Opcode), .A(A), .B(B), .N_bit(N_bit),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef DIVZ_CHECK_EN
    .res_err(res_err),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: add, sub, mul, div (0x00EE on zero divisor), shift-left, else xor.
  always_comb begin
    case (Opcode)
      4'd0:    alu_out = {8'd0, A} + {8'd0, B};
      4'd1:    alu_out = {8'd0, A} - {8'd0, B};
      4'd2:    alu_out = {8'd0, A} * {8'd0, B};
      4'd3:    alu_out = (B == 8'd0) ? 16'h00EE : ({8'd0, A} / {8'd0, B});
      4'd4:    alu_out = {8'd0, A} << N_bit;
      default: alu_out = {8'd0, A ^ B};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] n);
    cmd_valid  = v;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_nbit   = n;
  endtask

  // One command through an idle block with the consumer always ready.
  task automatic run_single(input string tag, input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [15:0] exp_data,
                            input logic exp_err);
    res_ready = 1'b1;
    drive(1'b1, op, a, b, 4'd0);
    step();
    drive(1'b0, 4'd0, 8'd0, 8'd0, 4'd0);
    check({tag, "_v_push"}, res_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    step();
    check({tag, "_op"}, Opcode, op);
    check({tag, "_a"}, A, a);
    check({tag, "_b"}, B, b);
    check({tag, "_v_pop"}, res_valid, 1'b0);
    step();
    check({tag, "_v_cap"}, res_valid, 1'b1);
    check({tag, "_data"}, res_data, exp_data);
`ifdef DIVZ_CHECK_EN
    check({tag, "_err"}, res_err, exp_err);
`else
    check({tag, "_err_unused"}, exp_err, 1'b0);
`endif
    step();
    check({tag, "_v_done"}, res_valid, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  logic [15:0] got_data [16];
  int          got_cyc  [16];
  int          n_got;
  logic [15:0] exp_fill [5];
  logic [15:0] exp_b2b  [4];

  initial begin
    rst = 1'b1;
    res_ready = 1'b0;
    drive(1'b0, 4'd0, 8'd0, 8'd0, 4'd0);
    step();
    step();
    check("rst_valid", res_valid, 1'b0);
    check("rst_data", res_data, 16'd0);
    check("rst_opA", {Opcode, A, B, N_bit}, 28'd0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step();
    check("post_rst_ready", cmd_ready, 1'b1);

    // Single add: 200 + 100.
    run_single("single", 4'd0, 8'd200, 8'd100, 16'd300, 1'b0);

    // Stall in HOLD: 15 * 17 held for 10 cycles.
    res_ready = 1'b0;
    drive(1'b1, 4'd2, 8'd15, 8'd17, 4'd3);
    step();
    drive(1'b0, 4'd0, 8'd0, 8'd0, 4'd0);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", res_valid, 1'b1);
      check("stall_data", res_data, 16'd255);
      check("stall_ops", {Opcode, A, B, N_bit}, {4'd2, 8'd15, 8'd17, 4'd3});
      step();
    end
    res_ready = 1'b1;
    step();
    check("stall_release", res_valid, 1'b0);
    step();
    check("stall_idle", busy, 1'b0);

    // Fill / backpressure with 5 pushes and DEPTH 4.
    exp_fill[0] = 16'd3;   exp_fill[1] = 16'd42;  exp_fill[2] = 16'd132;
    exp_fill[3] = 16'd48;  exp_fill[4] = 16'd510;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("fill_ready", cmd_ready, 1'b1);
      case (i)
        0: drive(1'b1, 4'd0, 8'd1, 8'd2, 4'd0);
        1: drive(1'b1, 4'd1, 8'd50, 8'd8, 4'd0);
        2: drive(1'b1, 4'd2, 8'd12, 8'd11, 4'd0);
        3: drive(1'b1, 4'd4, 8'd3, 8'd0, 4'd4);
        default: drive(1'b1, 4'd0, 8'd255, 8'd255, 4'd0);
      endcase
      step();
    end
    check("fill_full", cmd_ready, 1'b0);
    check("fill_head_ops", {Opcode, A, B}, {4'd0, 8'd1, 8'd2});
    check("fill_head_res", res_data, 16'd3);
    drive(1'b1, 4'd0, 8'd99, 8'd99, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fill_6th_blocked", cmd_ready, 1'b0);
    end
    drive(1'b0, 4'd0, 8'd0, 8'd0, 4'd0);
    res_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 30; c++) begin
      if (res_valid && n_got < 16) begin
        got_data[n_got] = res_data;
        n_got++;
      end
      step();
    end
    check("fill_count", n_got, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill_res%0d", i), got_data[i], exp_fill[i]);
    end
    check("fill_idle", busy, 1'b0);

    // Back-to-back: four ops, consumer always ready.
    exp_b2b[0] = 16'd30; exp_b2b[1] = 16'd99; exp_b2b[2] = 16'd256; exp_b2b[3] = 16'd28;
    n_got = 0;
    for (int c = 0; c < 30; c++) begin
      case (c)
        0: drive(1'b1, 4'd0, 8'd10, 8'd20, 4'd0);
        1: drive(1'b1, 4'd1, 8'd100, 8'd1, 4'd0);
        2: drive(1'b1, 4'd2, 8'd16, 8'd16, 4'd0);
        3: drive(1'b1, 4'd3, 8'd200, 8'd7, 4'd0);
        default: drive(1'b0, 4'd0, 8'd0, 8'd0, 4'd0);
      endcase
      step();
      if (res_valid && n_got < 16) begin
        got_data[n_got] = res_data;
        got_cyc[n_got]  = c;
        n_got++;
      end
    end
    check("b2b_count", n_got, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_res%0d", i), got_data[i], exp_b2b[i]);
      check($sformatf("b2b_cyc%0d", i), got_cyc[i], 2 + 2 * i);
    end

    // Divide: zero divisor then a normal divide.
`ifdef DIVZ_CHECK_EN
    run_single("divz", 4'd3, 8'd50, 8'd0, 16'hFFFF, 1'b1);
`else
    run_single("divz", 4'd3, 8'd50, 8'd0, 16'h00EE, 1'b0);
`endif
    run_single("div", 4'd3, 8'd50, 8'd5, 16'd10, 1'b0);

    // Reset while in HOLD with three commands queued.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd5, 8'(i + 1), 8'd7, 4'd1);
      step();
    end
    drive(1'b0, 4'd0, 8'd0, 8'd0, 4'd0);
    check("rh_pre_valid", res_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rh_valid", res_valid, 1'b0);
    check("rh_data", res_data, 16'd0);
    check("rh_ops", {Opcode, A, B, N_bit}, 28'd0);
    check("rh_busy", busy, 1'b0);
    check("rh_ready", cmd_ready, 1'b1);
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rh_no_result", res_valid, 1'b0);
    end
    run_single("rh_fresh", 4'd1, 8'd9, 8'd4, 16'd5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
